// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID->EX stage: ALU encodings, register indices,
// interlock FSM states and the decoded control bundle carried into EX.
package id_ex_stage_pkg;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    typedef struct packed {
        logic       regDst;
        logic       jump;
        logic       jal;
        logic       jumpRegister;
        logic       branch;
        logic       memRead;
        logic       memToReg;
        logic       memWrite;
        logic       aluSrc;
        logic       regWrite;
        logic       syscall;
        logic [2:0] aluOp;
    } ctrl_t;

    // A bubble is simply an all-zero control bundle.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs, EX-side registered outputs and the stall back-pressure
// of the ID->EX stage, bundled for connection between decode and EX.
interface id_ex_stage_if #(
    parameter int DATA_W = 32
);
    logic              id_valid;
    logic              id_regDst;
    logic              id_jump;
    logic              id_jal;
    logic              id_jumpRegister;
    logic              id_branch;
    logic              id_memRead;
    logic              id_memToReg;
    logic              id_memWrite;
    logic              id_aluSrc;
    logic              id_regWrite;
    logic              id_syscall;
    logic [2:0]        id_aluOp;
    logic [DATA_W-1:0] id_pc_plus4;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic              flush;

    logic              stall;
    logic              ex_valid;
    logic              ex_regDst;
    logic              ex_jump;
    logic              ex_jal;
    logic              ex_jumpRegister;
    logic              ex_branch;
    logic              ex_memRead;
    logic              ex_memToReg;
    logic              ex_memWrite;
    logic              ex_aluSrc;
    logic              ex_regWrite;
    logic              ex_syscall;
    logic [2:0]        ex_aluOp;
    logic [DATA_W-1:0] ex_pc_plus4;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;

    modport master (
        output id_valid, id_regDst, id_jump, id_jal, id_jumpRegister, id_branch,
               id_memRead, id_memToReg, id_memWrite, id_aluSrc, id_regWrite,
               id_syscall, id_aluOp, id_pc_plus4, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, flush,
        input  stall, ex_valid, ex_regDst, ex_jump, ex_jal, ex_jumpRegister,
               ex_branch, ex_memRead, ex_memToReg, ex_memWrite, ex_aluSrc,
               ex_regWrite, ex_syscall, ex_aluOp, ex_pc_plus4, ex_rs_data,
               ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd
    );

    modport slave (
        input  id_valid, id_regDst, id_jump, id_jal, id_jumpRegister, id_branch,
               id_memRead, id_memToReg, id_memWrite, id_aluSrc, id_regWrite,
               id_syscall, id_aluOp, id_pc_plus4, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, flush,
        output stall, ex_valid, ex_regDst, ex_jump, ex_jal, ex_jumpRegister,
               ex_branch, ex_memRead, ex_memToReg, ex_memWrite, ex_aluSrc,
               ex_regWrite, ex_syscall, ex_aluOp, ex_pc_plus4, ex_rs_data,
               ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use compare: a load in EX whose destination feeds a source of the
// instruction in ID. Writes to the zero register never create a dependency.
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_memRead,
    input  logic [4:0] ex_rt,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       lu
);

    assign lu = ex_valid & ex_memRead & (ex_rt != REG_ZERO) & id_valid &
                ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use, syscall-drain and flush interlocks.
// stall is combinational so the PC and IF/ID hold in the same cycle.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic         clk,
    input  logic         rst_b,
    id_ex_stage_if.slave bus
);

    localparam int               CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    generate
        if (DRAIN_CYCLES < 1) begin : g_drain_guard
            $error("id_ex_stage: DRAIN_CYCLES must be at least 1");
        end
    endgenerate

    state_e            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    ctrl_t             ex_ctrl_reg;
    ctrl_t             id_ctrl;
    logic              ex_valid_reg;
    logic [DATA_W-1:0] ex_pc_plus4_reg;
    logic [DATA_W-1:0] ex_rs_data_reg;
    logic [DATA_W-1:0] ex_rt_data_reg;
    logic [DATA_W-1:0] ex_imm_reg;
    logic [4:0]        ex_rs_reg;
    logic [4:0]        ex_rt_reg;
    logic [4:0]        ex_rd_reg;
    logic              lu;
    logic              stall_c;
    logic              load_id;

    assign id_ctrl = '{
        regDst:       bus.id_regDst,
        jump:         bus.id_jump,
        jal:          bus.id_jal,
        jumpRegister: bus.id_jumpRegister,
        branch:       bus.id_branch,
        memRead:      bus.id_memRead,
        memToReg:     bus.id_memToReg,
        memWrite:     bus.id_memWrite,
        aluSrc:       bus.id_aluSrc,
        regWrite:     bus.id_regWrite,
        syscall:      bus.id_syscall,
        aluOp:        bus.id_aluOp
    };

    hazard_detect u_hazard (
        .ex_valid   (ex_valid_reg),
        .ex_memRead (ex_ctrl_reg.memRead),
        .ex_rt      (ex_rt_reg),
        .id_valid   (bus.id_valid),
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .lu         (lu)
    );

    // Interlock priority: flush, then an active drain, then load-use, then advance.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall_c    = 1'b0;
        load_id    = 1'b0;
        if (bus.flush) begin
            state_next = ST_RUN;
            cnt_next   = '0;
        end else if (state_reg == ST_DRAIN) begin
            if (cnt_reg != '0) begin
                stall_c  = 1'b1;
                cnt_next = cnt_reg - CNT_W'(1);
            end else begin
                load_id    = 1'b1;
                state_next = ST_RUN;
            end
        end else if (lu) begin
            stall_c = 1'b1;
        end else if (bus.id_valid && bus.id_syscall) begin
            stall_c    = 1'b1;
            state_next = ST_DRAIN;
            cnt_next   = CNT_LOAD;
        end else begin
            load_id = 1'b1;
        end
    end

    assign bus.stall = stall_c & rst_b;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg       <= ST_RUN;
            cnt_reg         <= '0;
            ex_ctrl_reg     <= CTRL_BUBBLE;
            ex_valid_reg    <= 1'b0;
            ex_pc_plus4_reg <= '0;
            ex_rs_data_reg  <= '0;
            ex_rt_data_reg  <= '0;
            ex_imm_reg      <= '0;
            ex_rs_reg       <= '0;
            ex_rt_reg       <= '0;
            ex_rd_reg       <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (load_id) begin
                ex_ctrl_reg     <= id_ctrl;
                ex_valid_reg    <= bus.id_valid;
                ex_pc_plus4_reg <= bus.id_pc_plus4;
                ex_rs_data_reg  <= bus.id_rs_data;
                ex_rt_data_reg  <= bus.id_rt_data;
                ex_imm_reg      <= bus.id_imm;
                ex_rs_reg       <= bus.id_rs;
                ex_rt_reg       <= bus.id_rt;
                ex_rd_reg       <= bus.id_rd;
            end else begin
                // Data fields keep their old value under a bubble.
                ex_ctrl_reg  <= CTRL_BUBBLE;
                ex_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.ex_valid        = ex_valid_reg;
    assign bus.ex_regDst       = ex_ctrl_reg.regDst;
    assign bus.ex_jump         = ex_ctrl_reg.jump;
    assign bus.ex_jal          = ex_ctrl_reg.jal;
    assign bus.ex_jumpRegister = ex_ctrl_reg.jumpRegister;
    assign bus.ex_branch       = ex_ctrl_reg.branch;
    assign bus.ex_memRead      = ex_ctrl_reg.memRead;
    assign bus.ex_memToReg     = ex_ctrl_reg.memToReg;
    assign bus.ex_memWrite     = ex_ctrl_reg.memWrite;
    assign bus.ex_aluSrc       = ex_ctrl_reg.aluSrc;
    assign bus.ex_regWrite     = ex_ctrl_reg.regWrite;
    assign bus.ex_syscall      = ex_ctrl_reg.syscall;
    assign bus.ex_aluOp        = ex_ctrl_reg.aluOp;
    assign bus.ex_pc_plus4     = ex_pc_plus4_reg;
    assign bus.ex_rs_data      = ex_rs_data_reg;
    assign bus.ex_rt_data      = ex_rt_data_reg;
    assign bus.ex_imm          = ex_imm_reg;
    assign bus.ex_rs           = ex_rs_reg;
    assign bus.ex_rt           = ex_rt_reg;
    assign bus.ex_rd           = ex_rd_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, plain flow, load-use, syscall drain,
// flush during drain and flush versus load-use.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk;
    logic rst_b;
    int   checks;
    int   errors;

    id_ex_stage_if #(.DATA_W(32)) bus ();

    id_ex_stage #(.DATA_W(32), .DRAIN_CYCLES(3)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        bus.id_valid = 1'b0;        bus.id_regDst = 1'b0;   bus.id_jump = 1'b0;
        bus.id_jal = 1'b0;          bus.id_jumpRegister = 1'b0;
        bus.id_branch = 1'b0;       bus.id_memRead = 1'b0;  bus.id_memToReg = 1'b0;
        bus.id_memWrite = 1'b0;     bus.id_aluSrc = 1'b0;   bus.id_regWrite = 1'b0;
        bus.id_syscall = 1'b0;      bus.id_aluOp = 3'd0;
        bus.id_pc_plus4 = 32'd0;    bus.id_rs_data = 32'd0; bus.id_rt_data = 32'd0;
        bus.id_imm = 32'd0;         bus.id_rs = 5'd0;       bus.id_rt = 5'd0;
        bus.id_rd = 5'd0;           bus.flush = 1'b0;
    endtask

    task automatic drive_addi(input logic [31:0] imm, input logic [31:0] pc4);
        clear_id();
        bus.id_valid = 1'b1; bus.id_aluSrc = 1'b1; bus.id_regWrite = 1'b1;
        bus.id_aluOp = ALU_ADD; bus.id_imm = imm; bus.id_pc_plus4 = pc4;
        bus.id_rs = 5'd1; bus.id_rt = 5'd2;
    endtask

    task automatic drive_lw(input logic [4:0] rt);
        clear_id();
        bus.id_valid = 1'b1; bus.id_memRead = 1'b1; bus.id_memToReg = 1'b1;
        bus.id_aluSrc = 1'b1; bus.id_regWrite = 1'b1; bus.id_aluOp = ALU_ADD;
        bus.id_rs = 5'd29; bus.id_rt = rt; bus.id_imm = 32'h10;
    endtask

    task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        clear_id();
        bus.id_valid = 1'b1; bus.id_regDst = 1'b1; bus.id_regWrite = 1'b1;
        bus.id_aluOp = ALU_ADD; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    endtask

    task automatic drive_syscall(input logic [31:0] pc4);
        clear_id();
        bus.id_valid = 1'b1; bus.id_syscall = 1'b1; bus.id_pc_plus4 = pc4;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_id();
        rst_b = 1'b0;

        // Power-on reset
        tick();
        tick();
        #1 rst_b = 1'b1;
        #1;
        $display("reset released");
        chk1("rst_ex_valid", bus.ex_valid, 1'b0);
        chk1("rst_ex_regWrite", bus.ex_regWrite, 1'b0);
        chkw("rst_ex_imm", bus.ex_imm, 32'd0);
        chk1("rst_stall", bus.stall, 1'b0);

        // Plain ADDI flow
        drive_addi(32'h0000_0005, 32'h0000_0104);
        #1;
        $display("addi in ID imm=5");
        chk1("addi_stall", bus.stall, 1'b0);
        tick();
        chk1("addi_ex_aluSrc", bus.ex_aluSrc, 1'b1);
        chkw("addi_ex_imm", bus.ex_imm, 32'd5);
        chk1("addi_ex_valid", bus.ex_valid, 1'b1);
        chk1("addi_ex_regWrite", bus.ex_regWrite, 1'b1);
        chkw("addi_ex_aluOp", 32'(bus.ex_aluOp), 32'(ALU_ADD));
        chkw("addi_ex_pc_plus4", bus.ex_pc_plus4, 32'h0000_0104);
        chkw("addi_ex_rt", 32'(bus.ex_rt), 32'd2);

        // Mid-cycle async reset with a valid instruction in EX
        bus.id_syscall = 1'b1;
        #1;
        $display("syscall in ID before reset");
        chk1("presrst_stall", bus.stall, 1'b1);
        rst_b = 1'b0;
        #1;
        $display("async reset asserted mid-cycle");
        chk1("arst_ex_valid", bus.ex_valid, 1'b0);
        chk1("arst_ex_aluSrc", bus.ex_aluSrc, 1'b0);
        chkw("arst_ex_imm", bus.ex_imm, 32'd0);
        chkw("arst_ex_pc_plus4", bus.ex_pc_plus4, 32'd0);
        chk1("arst_stall", bus.stall, 1'b0);
        clear_id();
        tick();
        #1 rst_b = 1'b1;

        // Load-use with rt=8
        drive_lw(5'd8);
        #1;
        $display("lw rt=8 in ID");
        chk1("lw8_stall", bus.stall, 1'b0);
        tick();
        chk1("lw8_ex_memRead", bus.ex_memRead, 1'b1);
        chkw("lw8_ex_rt", 32'(bus.ex_rt), 32'd8);
        drive_add(5'd8, 5'd9, 5'd10);
        #1;
        $display("add rs=8 in ID behind lw");
        chk1("lu_stall", bus.stall, 1'b1);
        tick();
        chk1("lu_bubble_valid", bus.ex_valid, 1'b0);
        chk1("lu_bubble_regWrite", bus.ex_regWrite, 1'b0);
        chk1("lu_bubble_memRead", bus.ex_memRead, 1'b0);
        chkw("lu_bubble_rt_held", 32'(bus.ex_rt), 32'd8);
        chk1("lu_stall_released", bus.stall, 1'b0);
        tick();
        $display("add reaches EX");
        chk1("lu_add_valid", bus.ex_valid, 1'b1);
        chkw("lu_add_rs", 32'(bus.ex_rs), 32'd8);
        chkw("lu_add_rd", 32'(bus.ex_rd), 32'd10);
        chk1("lu_add_regDst", bus.ex_regDst, 1'b1);

        // Load to the zero register never interlocks
        drive_lw(5'd0);
        #1;
        chk1("lw0_stall", bus.stall, 1'b0);
        tick();
        chk1("lw0_ex_memRead", bus.ex_memRead, 1'b1);
        drive_add(5'd0, 5'd9, 5'd11);
        #1;
        $display("add rs=0 behind lw rt=0");
        chk1("lu0_stall", bus.stall, 1'b0);
        tick();
        chk1("lu0_ex_valid", bus.ex_valid, 1'b1);
        chkw("lu0_ex_rd", 32'(bus.ex_rd), 32'd11);

        // Syscall drain: three bubbles then the syscall
        drive_syscall(32'h0000_0200);
        for (int e = 1; e <= 3; e++) begin
            #1;
            $display("drain cycle %0d", e);
            chk1("drain_stall", bus.stall, 1'b1);
            tick();
            chk1("drain_bubble_valid", bus.ex_valid, 1'b0);
            chk1("drain_bubble_syscall", bus.ex_syscall, 1'b0);
        end
        chk1("drain_done_stall", bus.stall, 1'b0);
        tick();
        $display("syscall reaches EX");
        chk1("sys_ex_syscall", bus.ex_syscall, 1'b1);
        chk1("sys_ex_valid", bus.ex_valid, 1'b1);
        chkw("sys_ex_pc_plus4", bus.ex_pc_plus4, 32'h0000_0200);
        clear_id();
        tick();

        // Flush in the second drain cycle
        drive_syscall(32'h0000_0300);
        #1;
        chk1("fdrain_stall1", bus.stall, 1'b1);
        tick();
        chk1("fdrain_stall2", bus.stall, 1'b1);
        tick();
        bus.flush = 1'b1;
        #1;
        $display("flush during drain");
        chk1("fdrain_flush_stall", bus.stall, 1'b0);
        tick();
        chk1("fdrain_bubble_valid", bus.ex_valid, 1'b0);
        chk1("fdrain_bubble_syscall", bus.ex_syscall, 1'b0);
        drive_addi(32'h0000_0007, 32'h0000_0400);
        #1;
        chk1("fdrain_run_stall", bus.stall, 1'b0);
        tick();
        chkw("fdrain_ex_imm", bus.ex_imm, 32'd7);
        chk1("fdrain_ex_valid", bus.ex_valid, 1'b1);
        chk1("fdrain_ex_syscall", bus.ex_syscall, 1'b0);

        // Flush and load-use together: flush wins
        drive_lw(5'd5);
        #1;
        chk1("flu_lw_stall", bus.stall, 1'b0);
        tick();
        drive_add(5'd5, 5'd6, 5'd12);
        bus.flush = 1'b1;
        #1;
        $display("flush with load-use pending");
        chk1("flu_stall", bus.stall, 1'b0);
        tick();
        chk1("flu_bubble_valid", bus.ex_valid, 1'b0);
        chk1("flu_bubble_memRead", bus.ex_memRead, 1'b0);
        chkw("flu_bubble_rt_held", 32'(bus.ex_rt), 32'd5);
        bus.flush = 1'b0;

        // Invalid syscall in ID never starts a drain
        clear_id();
        bus.id_syscall = 1'b1;
        #1;
        $display("invalid syscall in ID");
        chk1("inv_sys_stall", bus.stall, 1'b0);
        tick();
        chk1("inv_sys_ex_valid", bus.ex_valid, 1'b0);
        drive_addi(32'h0000_0009, 32'h0000_0500);
        #1;
        chk1("inv_sys_next_stall", bus.stall, 1'b0);
        tick();
        chkw("inv_sys_next_imm", bus.ex_imm, 32'd9);
        chk1("inv_sys_next_valid", bus.ex_valid, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
